// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver.
//   state_t      : 3-bit frame state encoding (IDLE/START/DATA/PARITY/STOP)
//   PARITY_*     : parity mode codes carried on parity_type
//   norm_parity  : folds the spare code 3 onto "no parity"
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_ODD  = 2'd1;
  localparam logic [1:0] PARITY_EVEN = 2'd2;

  function automatic logic [1:0] norm_parity(input logic [1:0] p);
    return (p == 2'd3) ? PARITY_NONE : p;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Transmit-side handshake bundle between a word source and uart_tx.
//   tx_start        : request to send tx_data (source -> uart_tx)
//   tx_data         : DATA_BITS-wide word to send (source -> uart_tx)
//   parity_type     : 0 none, 1 odd, 2 even, 3 none (source -> uart_tx)
//   serial_data_out : serial line, idle high (uart_tx -> line)
//   tx_busy         : frame in progress (uart_tx -> source)
//   tx_done         : one-cycle pulse in the last cycle of the frame (uart_tx -> source)
// Modports: master = word source, slave = uart_tx.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic [1:0]           parity_type;
  logic                 serial_data_out;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_start, tx_data, parity_type,
    input  serial_data_out, tx_busy, tx_done
  );

  modport slave (
    input  tx_start, tx_data, parity_type,
    output serial_data_out, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter shared by the UART transmitter and receiver.
// Counts 0..CLOCKS_PER_BIT-1 and wraps on its own at the terminal count.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   clear       : hold the count at zero (used while the line is idle)
//   bit_end     : high during the last cycle of a bit period
//   bit_pre_end : high during the second-to-last cycle of a bit period, so a
//                 caller can register a flag that lines up with bit_end
// CLOCKS_PER_BIT must be at least 2.
module uart_bit_timer #(
  parameter int CLOCKS_PER_BIT  = 434,
  parameter int CLOCK_CTR_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end,
  output logic bit_pre_end
);

  logic [CLOCK_CTR_WIDTH-1:0] r_count;

  assign bit_end     = (r_count == CLOCK_CTR_WIDTH'(CLOCKS_PER_BIT - 1));
  assign bit_pre_end = (r_count == CLOCK_CTR_WIDTH'(CLOCKS_PER_BIT - 2));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (bit_end) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serialises one word per request into
// start(0), DATA_BITS data bits LSB first, optional parity, stop bit(s)(1).
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset (aborts any frame, line high)
//   bus  : uart_tx_if.slave (tx_start, tx_data, parity_type in;
//          serial_data_out, tx_busy, tx_done out)
// Build option: UART_TX_TWO_STOP_BITS_EN defined -> two stop bits,
// otherwise one stop bit.
// CLOCKS_PER_BIT must be at least 2.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT  = 434,
  parameter int DATA_BITS       = 8,
  parameter int CLOCK_CTR_WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

`ifdef UART_TX_TWO_STOP_BITS_EN
  localparam logic STOP_LAST = 1'b1;
`else
  localparam logic STOP_LAST = 1'b0;
`endif

  state_t               r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_word;
  logic [1:0]           r_parity;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_stop_idx;
  logic                 r_line;
  logic                 r_busy;
  logic                 r_done;

  logic w_bit_end;
  logic w_bit_pre_end;
  logic w_last_stop;
  logic w_par_bit;

  // The timer is held at zero in IDLE so the first START cycle is count 0.
  uart_bit_timer #(
    .CLOCKS_PER_BIT (CLOCKS_PER_BIT),
    .CLOCK_CTR_WIDTH(CLOCK_CTR_WIDTH)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (r_state == IDLE),
    .bit_end    (w_bit_end),
    .bit_pre_end(w_bit_pre_end)
  );

  assign w_last_stop = (r_stop_idx == STOP_LAST);
  // Parity from the captured word, since r_shift is consumed by then.
  assign w_par_bit   = (r_parity == PARITY_EVEN) ? (^r_word) : (~^r_word);

  assign bus.serial_data_out = r_line;
  assign bus.tx_busy         = r_busy;
  assign bus.tx_done         = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_word     <= '0;
      r_parity   <= PARITY_NONE;
      r_idx      <= '0;
      r_stop_idx <= 1'b0;
      r_line     <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_line <= 1'b1;
          r_busy <= 1'b0;
          if (bus.tx_start) begin
            r_shift  <= bus.tx_data;
            r_word   <= bus.tx_data;
            r_parity <= norm_parity(bus.parity_type);
            r_line   <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_line  <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_idx   <= '0;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (r_idx == IDX_W'(DATA_BITS - 1)) begin
              r_stop_idx <= 1'b0;
              if (r_parity != PARITY_NONE) begin
                r_line  <= w_par_bit;
                r_state <= PARITY;
              end else begin
                r_line  <= 1'b1;
                r_state <= STOP;
              end
            end else begin
              r_line  <= r_shift[0];
              r_shift <= r_shift >> 1;
              r_idx   <= r_idx + 1'b1;
            end
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_line  <= 1'b1;
            r_state <= STOP;
          end
        end
        STOP: begin
          // Raised one cycle early so the registered pulse lands on the final cycle.
          if (w_bit_pre_end && w_last_stop) begin
            r_done <= 1'b1;
          end
          if (w_bit_end) begin
            if (w_last_stop) begin
              r_line  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          r_line  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
